ysyx_icache: RTL and testbench

Parametrised, direct-mapped, multi-word-line L1 instruction cache with valid/ready handshakes on both sides. It sits between the IFU fetch request port and the instruction bus arbiter. Hits return in one cycle at a sustained rate of one fetch per cycle; misses refill a whole line with sequential single-word bus reads. It adds `fence.i` flush and hit/miss performance counters.

---
 rtl/ysyx_icache.sv | 153 +++++++++++++++
 tb/tb_ysyx_icache.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_icache.sv
// Direct-mapped, multi-word-line L1 instruction cache between the IFU and the instruction bus.
// Hits answer the cycle after accept; misses refill a whole line one single-word read at a time.
module ysyx_icache #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int SETS       = 16,
    parameter int LINE_WORDS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_inst,
    output logic [ADDR_W-1:0] resp_pc,
    input  logic              flush,
    output logic [ADDR_W-1:0] mem_araddr,
    output logic              mem_arvalid,
    input  logic              mem_arready,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rvalid,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
);
    localparam int OFF_W = $clog2(LINE_WORDS) + 2;
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REFILL = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t            r_state;
    logic [SETS-1:0]   r_valid;
    logic [TAG_W-1:0]  r_tag  [SETS];
    logic [DATA_W-1:0] r_data [SETS*LINE_WORDS];
    logic [ADDR_W-1:0] r_addr;
    logic              r_flush_pend;

    logic [IDX_W-1:0]  w_req_idx;
    logic [TAG_W-1:0]  w_req_tag;
    logic              w_hit;
    logic [DATA_W-1:0] w_hit_word;
    logic              w_accept;
    logic              w_beat;
    logic              w_last;
    logic [IDX_W-1:0]  w_fill_idx;
    logic              w_flush_any;

    // Lookup, handshake and refill-beat decode; mem_araddr doubles as the beat pointer.
    always_comb begin
        w_req_idx   = req_addr[IDX_W+OFF_W-1:OFF_W];
        w_req_tag   = req_addr[ADDR_W-1:IDX_W+OFF_W];
        w_hit       = r_valid[w_req_idx] && (r_tag[w_req_idx] == w_req_tag);
        w_hit_word  = r_data[req_addr[IDX_W+OFF_W-1:2]];
        req_ready   = !flush && ((r_state == S_IDLE) || ((r_state == S_RESP) && resp_ready));
        w_accept    = req_valid && req_ready;
        w_beat      = (r_state == S_REFILL) && !mem_arvalid && mem_rvalid;
        w_last      = &(mem_araddr[OFF_W-1:0] | OFF_W'(2'b11));
        w_fill_idx  = mem_araddr[IDX_W+OFF_W-1:OFF_W];
        w_flush_any = flush || r_flush_pend;
    end

    // Line storage: written only by refill beats and deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (w_beat) begin
            r_data[mem_araddr[IDX_W+OFF_W-1:2]] <= mem_rdata;
            if (w_last) begin
                r_tag[w_fill_idx] <= r_addr[ADDR_W-1:IDX_W+OFF_W];
            end
        end
    end

    // Control FSM with registered response, bus request, valid bits and counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_valid      <= {SETS{1'b0}};
            r_addr       <= {ADDR_W{1'b0}};
            r_flush_pend <= 1'b0;
            resp_valid   <= 1'b0;
            resp_inst    <= {DATA_W{1'b0}};
            resp_pc      <= {ADDR_W{1'b0}};
            mem_arvalid  <= 1'b0;
            mem_araddr   <= {ADDR_W{1'b0}};
            hit_cnt      <= 32'd0;
            miss_cnt     <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE, S_RESP: begin
                    if (flush) begin
                        r_valid <= {SETS{1'b0}};
                    end
                    if ((r_state == S_RESP) && resp_ready) begin
                        resp_valid <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                    if (w_accept) begin
                        r_addr <= req_addr;
                        if (w_hit) begin
                            r_state    <= S_RESP;
                            resp_valid <= 1'b1;
                            resp_inst  <= w_hit_word;
                            resp_pc    <= req_addr;
                            hit_cnt    <= hit_cnt + 32'd1;
                        end else begin
                            r_state      <= S_REFILL;
                            miss_cnt     <= miss_cnt + 32'd1;
                            mem_arvalid  <= 1'b1;
                            mem_araddr   <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                            r_flush_pend <= 1'b0;
                        end
                    end
                end
                S_REFILL: begin
                    if (flush) begin
                        r_flush_pend <= 1'b1;
                    end
                    if (mem_arvalid && mem_arready) begin
                        mem_arvalid <= 1'b0;
                    end
                    if (w_beat) begin
                        if (mem_araddr[ADDR_W-1:2] == r_addr[ADDR_W-1:2]) begin
                            resp_inst <= mem_rdata;
                        end
                        if (w_last) begin
                            r_state      <= S_RESP;
                            resp_valid   <= 1'b1;
                            resp_pc      <= r_addr;
                            r_flush_pend <= 1'b0;
                            // A flush seen during the refill leaves even the new line invalid.
                            if (w_flush_any) begin
                                r_valid <= {SETS{1'b0}};
                            end else begin
                                r_valid[w_fill_idx] <= 1'b1;
                            end
                        end else begin
                            mem_araddr  <= mem_araddr + ADDR_W'(3'd4);
                            mem_arvalid <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ysyx_icache.sv
// Scoreboard bench for ysyx_icache: a set/line-address cache model predicts hits, bus reads and responses.
module tb_ysyx_icache;
    localparam int SETS  = 16;
    localparam int OFF_W = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = 32'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_inst;
    logic [31:0] resp_pc;
    logic        flush = 1'b0;
    logic [31:0] mem_araddr;
    logic        mem_arvalid;
    logic        mem_arready = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    ysyx_icache #(.ADDR_W(32), .DATA_W(32), .SETS(SETS), .LINE_WORDS(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_inst(resp_inst), .resp_pc(resp_pc),
        .flush(flush),
        .mem_araddr(mem_araddr), .mem_arvalid(mem_arvalid), .mem_arready(mem_arready),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Reference model: which line base address each set holds, plus expected traffic.
    logic [31:0] m_line [SETS];
    bit          m_v    [SETS];
    int          exp_hit  = 0;
    int          exp_miss = 0;
    logic [31:0] q_rd[$];
    logic [31:0] q_pc[$];
    logic [31:0] q_inst[$];
    int          n_rd   = 0;
    int          n_resp = 0;

    task automatic model_clear();
        for (int i = 0; i < SETS; i++) m_v[i] = 1'b0;
    endtask

    task automatic model_accept(input logic [31:0] a);
        int          idx;
        logic [31:0] base;
        idx  = int'((a >> OFF_W) % SETS);
        base = a & 32'hFFFF_FFF0;
        if (m_v[idx] && m_line[idx] == base) begin
            exp_hit++;
        end else begin
            exp_miss++;
            for (int k = 0; k < 4; k++) q_rd.push_back(base + 32'(4 * k));
            m_v[idx]    = 1'b1;
            m_line[idx] = base;
        end
        q_pc.push_back(a);
        q_inst.push_back(mem_word(a));
    endtask

    // Bus slave: 0 = zero-wait, 1 = random waits, 2 = address never accepted.
    int          bus_mode = 0;
    bit          pend = 1'b0;
    int          pend_dly = 0;
    logic [31:0] pend_addr = 32'd0;
    always @(negedge clk) begin
        mem_arready = 1'b0;
        mem_rvalid  = 1'b0;
        mem_rdata   = $urandom;
        if (!rst) begin
            pend = 1'b0;
        end else if (pend) begin
            if (pend_dly == 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = mem_word(pend_addr);
                pend       = 1'b0;
            end else begin
                pend_dly--;
            end
        end else if (mem_arvalid) begin
            if (bus_mode == 0 || (bus_mode == 1 && $urandom_range(0, 1) == 1)) begin
                mem_arready = 1'b1;
                pend        = 1'b1;
                pend_addr   = mem_araddr;
                pend_dly    = (bus_mode == 0) ? 0 : int'($urandom_range(0, 2));
            end
        end
    end

    bit rr_rand = 1'b0;
    always @(negedge clk) begin
        if (rr_rand) resp_ready = ($urandom_range(0, 3) != 0);
    end

    // Monitor: pops expectations on every handshake and checks hold-stability of both outputs.
    bit          hold_r = 1'b0;
    logic [31:0] hold_inst, hold_pc;
    bit          ar_hold = 1'b0;
    logic [31:0] ar_hold_addr;
    always @(negedge clk) begin
        #1;
        if (!rst) begin
            hold_r  = 1'b0;
            ar_hold = 1'b0;
        end else begin
            if (hold_r) begin
                check("resp_hold_valid", 32'(resp_valid), 32'd1);
                check("resp_hold_inst", resp_inst, hold_inst);
                check("resp_hold_pc", resp_pc, hold_pc);
            end
            if (ar_hold) begin
                check("ar_hold_valid", 32'(mem_arvalid), 32'd1);
                check("ar_hold_addr", mem_araddr, ar_hold_addr);
            end
            if (resp_valid && resp_ready) begin
                n_resp++;
                if (q_pc.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL resp_unexpected: got pc 0x%08h expected no response", resp_pc);
                end else begin
                    check("resp_pc", resp_pc, q_pc.pop_front());
                    check("resp_inst", resp_inst, q_inst.pop_front());
                end
            end
            if (mem_arvalid && mem_arready) begin
                n_rd++;
                if (q_rd.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL rd_unexpected: got addr 0x%08h expected no read", mem_araddr);
                end else begin
                    check("rd_addr", mem_araddr, q_rd.pop_front());
                end
            end
            hold_r       = resp_valid && !resp_ready;
            hold_inst    = resp_inst;
            hold_pc      = resp_pc;
            ar_hold      = mem_arvalid && !mem_arready;
            ar_hold_addr = mem_araddr;
        end
    end

    // Called just after a negedge; returns just after the negedge following the accept.
    task automatic issue(input logic [31:0] a);
        int t;
        t = 0;
        req_valid = 1'b1;
        req_addr  = a;
        #1;
        while (!req_ready && t < 300) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (!req_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: got req_ready 0 expected 1 for 0x%08h", a);
        end else begin
            model_accept(a);
        end
        @(negedge clk);
    endtask

    task automatic do_flush();
        req_valid = 1'b0;
        flush     = 1'b1;
        model_clear();
        @(negedge clk);
        flush = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        req_valid  = 1'b0;
        rr_rand    = 1'b0;
        resp_ready = 1'b1;
        #2;
        while ((q_pc.size() != 0 || q_rd.size() != 0 || resp_valid) && t < 600) begin
            @(negedge clk);
            #2;
            t++;
        end
        if (t >= 600) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d responses outstanding expected 0", q_pc.size());
        end
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        int          r0;
        int          t;
        time         t0;
        logic [31:0] a;
        model_clear();
        #3;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_inst", resp_inst, 32'd0);
        check("rst_resp_pc", resp_pc, 32'd0);
        check("rst_arvalid", 32'(mem_arvalid), 32'd0);
        check("rst_araddr", mem_araddr, 32'd0);
        check("rst_hit_cnt", hit_cnt, 32'd0);
        check("rst_miss_cnt", miss_cnt, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst        = 1'b1;
        resp_ready = 1'b1;

        // Cold miss on a zero-wait bus: response in cycle 9 counting the accept cycle as 0.
        bus_mode = 0;
        issue(32'h8000_0004);
        req_valid = 1'b0;
        lat = 1;
        #1;
        while (!resp_valid && lat < 50) begin
            @(negedge clk);
            #1;
            lat++;
        end
        check("miss_latency", 32'(lat), 32'd9);
        @(negedge clk);
        wait_idle();
        check("cold_miss_cnt", miss_cnt, 32'(exp_miss));
        check("cold_reads", 32'(n_rd), 32'd4);

        // Hits on the same line stream one per cycle with no bus traffic.
        r0 = n_rd;
        lat = n_resp;
        t0 = $time;
        issue(32'h8000_0000);
        issue(32'h8000_0008);
        issue(32'h8000_000C);
        req_valid = 1'b0;
        check("stream_cycles", 32'(($time - t0) / 10), 32'd3);
        #2;
        check("stream_resps", 32'(n_resp - lat), 32'd3);
        wait_idle();
        check("stream_hit_cnt", hit_cnt, 32'(exp_hit));
        check("stream_no_reads", 32'(n_rd - r0), 32'd0);

        // Conflicting lines in set 0 evict each other.
        bus_mode = 1;
        r0 = n_rd;
        issue(32'h8000_0100);
        issue(32'h8000_0000);
        issue(32'h8000_0100);
        wait_idle();
        check("conflict_miss_cnt", miss_cnt, 32'(exp_miss));
        check("conflict_reads", 32'(n_rd - r0), 32'd12);

        // Backpressure on a hit: response frozen and no new request accepted.
        resp_ready = 1'b0;
        issue(32'h8000_0100);
        req_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_resp_valid", 32'(resp_valid), 32'd1);
            check("bp_req_ready", 32'(req_ready), 32'd0);
            check("bp_resp_pc", resp_pc, 32'h8000_0100);
            check("bp_resp_inst", resp_inst, mem_word(32'h8000_0100));
            @(negedge clk);
        end
        wait_idle();
        check("bp_hit_cnt", hit_cnt, 32'(exp_hit));

        // Flush during beat 2 of a refill; the line must miss again afterwards.
        r0 = n_rd;
        issue(32'h8000_0040);
        req_valid = 1'b0;
        t = 0;
        #2;
        while (n_rd < r0 + 2 && t < 100) begin
            @(negedge clk);
            #2;
            t++;
        end
        @(negedge clk);
        do_flush();
        wait_idle();
        issue(32'h8000_0040);
        wait_idle();
        check("flush_refill_miss_cnt", miss_cnt, 32'(exp_miss));
        issue(32'h8000_0000);
        issue(32'h8000_0000);
        wait_idle();
        check("pre_flush_hit_cnt", hit_cnt, 32'(exp_hit));
        do_flush();
        issue(32'h8000_0000);
        wait_idle();
        check("flush_idle_miss_cnt", miss_cnt, 32'(exp_miss));

        // Random traffic: mixed hits, conflicts, flushes, bus waits and backpressure.
        rr_rand = 1'b1;
        for (int i = 0; i < 300; i++) begin
            t = int'($urandom_range(0, 19));
            if (t == 0) begin
                do_flush();
            end else if (t < 5) begin
                req_valid = 1'b0;
                @(negedge clk);
            end else begin
                a = 32'h8000_0000 + ($urandom_range(0, 63) << 2) + ($urandom_range(0, 2) << 8);
                issue(a);
            end
        end
        wait_idle();
        check("rand_hit_cnt", hit_cnt, 32'(exp_hit));
        check("rand_miss_cnt", miss_cnt, 32'(exp_miss));

        // Asynchronous reset while a refill is stalled on the address channel.
        bus_mode = 2;
        do_flush();
        issue(32'h8000_0000);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("stall_arvalid", 32'(mem_arvalid), 32'd1);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("async_arvalid", 32'(mem_arvalid), 32'd0);
        check("async_resp_valid", 32'(resp_valid), 32'd0);
        q_rd.delete();
        q_pc.delete();
        q_inst.delete();
        model_clear();
        exp_hit  = 0;
        exp_miss = 0;
        bus_mode = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("post_rst_hit_cnt", hit_cnt, 32'd0);
        check("post_rst_miss_cnt", miss_cnt, 32'd0);
        @(negedge clk);
        issue(32'h8000_0000);
        wait_idle();
        check("post_rst_miss", miss_cnt, 32'(exp_miss));
        check("post_rst_hit", hit_cnt, 32'(exp_hit));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
